// File: rtl/cn_ff_driver_pkg.sv
// Shared definitions for the C/N flip-flop command driver: FSM states and
// the {c,n} command encodings placed on the bus.
package cn_ff_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Command encodings, packed as {c, n}
    localparam logic [1:0] CN_HOLD = 2'b00;
    localparam logic [1:0] CN_SET  = 2'b11;
    localparam logic [1:0] CN_CLR  = 2'b01;

endpackage

// File: rtl/cn_ff_driver_excite.sv
// Excitation table for a C/N flip-flop: given the shadow value s and the
// target t, produce the {c,n} command that moves q from s to t.
module cn_ff_driver_excite
    import cn_ff_driver_pkg::*;
(
    input  logic s,
    input  logic t,
    output logic c,
    output logic n
);

    logic [1:0] cn;

    // Hold when already at target, otherwise set (0->1) or clear (1->0)
    always_comb begin
        cn = CN_HOLD;
        if (s != t) begin
            cn = t ? CN_SET : CN_CLR;
        end
    end

    assign c = cn[1];
    assign n = cn[0];

endmodule

// File: rtl/cn_ff_driver.sv
// Serialises a target word into one C/N command per clock for an external
// C/N flip-flop, tracks q with a shadow bit, and checks the fed-back q two
// cycles after each command to flag any mismatch for the word.
module cn_ff_driver
    import cn_ff_driver_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       cn_c,
    output logic                       cn_n,
    input  logic                       ff_q,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(WIDTH+1)-1:0] n_changes
);

    localparam int IW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    bit_idx;
    logic             drain_cnt;
    logic             shadow;
    logic             exp1;
    logic             exp2;
    logic             vld1;
    logic             vld2;
    logic             tgt;
    logic             nxt_c;
    logic             nxt_n;
    logic             accept;
    logic             last_bit;
    logic             mismatch;

    assign accept   = in_valid && (state == ST_IDLE);
    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign tgt      = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
    assign last_bit = (bit_idx == IW'(WIDTH - 1));
    // Command registered two edges ago has now been sampled by the FF
    assign mismatch = vld2 && (ff_q != exp2);

    cn_ff_driver_excite u_excite (
        .s (shadow),
        .t (tgt),
        .c (nxt_c),
        .n (nxt_n)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one word walks IDLE -> DRIVE -> DRAIN -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept)    state_next = ST_DRIVE;
            ST_DRIVE: if (last_bit)  state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Datapath: shift register, shadow, command bus, check pipe and counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg     <= '0;
            bit_idx   <= '0;
            drain_cnt <= 1'b0;
            shadow    <= 1'b0;
            exp1      <= 1'b0;
            exp2      <= 1'b0;
            vld1      <= 1'b0;
            vld2      <= 1'b0;
            cn_c      <= 1'b0;
            cn_n      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            n_changes <= '0;
        end else begin
            cn_c <= 1'b0;
            cn_n <= 1'b0;
            done <= 1'b0;
            vld1 <= 1'b0;
            vld2 <= vld1;
            exp2 <= exp1;
            if (mismatch) begin
                err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg     <= in_data;
                        shadow    <= ff_q;
                        err       <= 1'b0;
                        n_changes <= '0;
                        bit_idx   <= '0;
                        drain_cnt <= 1'b0;
                        vld2      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    cn_c      <= nxt_c;
                    cn_n      <= nxt_n;
                    shadow    <= tgt;
                    exp1      <= tgt;
                    vld1      <= 1'b1;
                    shreg     <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
                    bit_idx   <= bit_idx + 1'b1;
                    drain_cnt <= 1'b0;
                    if (nxt_n) begin
                        n_changes <= n_changes + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
